// File: rtl/rv_dmem_responder.sv
// Data-memory responder for the uRV load/store path: one request at a time,
// a fixed number of wait states, then a one-cycle load or store completion pulse.
module rv_dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [3:0]            sel_q;
    logic                  store_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  accept;
    logic                  in_wait;
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_data;
    logic [3:0]            acc_sel;
    logic                  acc_store;
    logic                  mem_we;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dm_addr_i[31:ADDR_WIDTH+2], dm_addr_i[1:0]};

    assign dm_ready_o = (state == ST_IDLE) || (state == ST_RESP);
    assign accept     = dm_ready_o && (dm_load_i || dm_store_i);
    assign in_wait    = (state == ST_WAIT);

    // With no wait states the array is accessed at the accept edge itself,
    // so the live request is used; otherwise the latched copy is.
    assign acc_addr  = in_wait ? addr_q  : dm_addr_i[ADDR_WIDTH+1:2];
    assign acc_data  = in_wait ? data_q  : dm_data_s_i;
    assign acc_sel   = in_wait ? sel_q   : dm_data_select_i;
    assign acc_store = in_wait ? store_q : dm_store_i;

    assign enter_resp = (in_wait && (cnt == 4'd0)) || (accept && (WAIT_STATES == 0));
    assign mem_we     = enter_resp && acc_store && !rst_i;

    // NOTE: the array has no reset; clearing it would forbid RAM inference,
    // and its contents are defined only by stores.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) mem[acc_addr][8*b +: 8] <= acc_data[8*b +: 8];
            end
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers
    // observe pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            cnt             <= 4'd0;
            addr_q          <= '0;
            data_q          <= 32'd0;
            sel_q           <= 4'd0;
            store_q         <= 1'b0;
            dm_data_l_o     <= 32'd0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
        end else begin
            dm_load_done_o  <= enter_resp && !acc_store;
            dm_store_done_o <= enter_resp && acc_store;
            if (enter_resp && !acc_store) dm_data_l_o <= mem[acc_addr];

            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        addr_q  <= dm_addr_i[ADDR_WIDTH+1:2];
                        data_q  <= dm_data_s_i;
                        sel_q   <= dm_data_select_i;
                        store_q <= dm_store_i;  // store wins over a simultaneous load
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench for rv_dmem_responder: three instances cover zero, two and
// three wait states; expected values are hand-computed constants.
module tb_rv_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  sel   [3];
    logic        ld    [3];
    logic        st    [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        ldone [3];
    logic        sdone [3];

    int checks = 0;
    int errors = 0;

    rv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst[0]), .dm_addr_i(addr[0]), .dm_data_s_i(wdata[0]),
        .dm_data_select_i(sel[0]), .dm_load_i(ld[0]), .dm_store_i(st[0]),
        .dm_ready_o(ready[0]), .dm_data_l_o(rdata[0]),
        .dm_load_done_o(ldone[0]), .dm_store_done_o(sdone[0])
    );

    rv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_i(rst[1]), .dm_addr_i(addr[1]), .dm_data_s_i(wdata[1]),
        .dm_data_select_i(sel[1]), .dm_load_i(ld[1]), .dm_store_i(st[1]),
        .dm_ready_o(ready[1]), .dm_data_l_o(rdata[1]),
        .dm_load_done_o(ldone[1]), .dm_store_done_o(sdone[1])
    );

    rv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .rst_i(rst[2]), .dm_addr_i(addr[2]), .dm_data_s_i(wdata[2]),
        .dm_data_select_i(sel[2]), .dm_load_i(ld[2]), .dm_store_i(st[2]),
        .dm_ready_o(ready[2]), .dm_data_l_o(rdata[2]),
        .dm_load_done_o(ldone[2]), .dm_store_done_o(sdone[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int u, input logic l, input logic s, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        ld[u]    = l;
        st[u]    = s;
        addr[u]  = a;
        wdata[u] = d;
        sel[u]   = m;
    endtask

    task automatic idle(input int u);
        ld[u] = 1'b0;
        st[u] = 1'b0;
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1;
            req(u, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        end

        // Reset, then ten idle cycles
        tick();
        tick();
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_ready%0d", u), ready[u], 1);
            check($sformatf("rst_data%0d", u),  rdata[u], 32'h0);
            check($sformatf("rst_ldone%0d", u), ldone[u], 0);
            check($sformatf("rst_sdone%0d", u), sdone[u], 0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ready", ready[0], 1);
            check("idle_dones", {ldone[0], sdone[0], ldone[1], sdone[1]}, 0);
        end

        // Zero wait states: store then back-to-back load from the RESP cycle
        req(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b1111);
        tick();
        check("ws0_st_sdone", sdone[0], 1);
        check("ws0_st_ldone", ldone[0], 0);
        check("ws0_st_ready", ready[0], 1);
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'b0000);
        tick();
        check("ws0_ld_ldone", ldone[0], 1);
        check("ws0_ld_sdone", sdone[0], 0);
        check("ws0_ld_data",  rdata[0], 32'hDEADBEEF);
        idle(0);
        tick();
        check("ws0_idle_ldone", ldone[0], 0);
        check("ws0_idle_ready", ready[0], 1);
        check("ws0_hold_data",  rdata[0], 32'hDEADBEEF);

        // Byte-enable merge
        req(0, 1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0101);
        tick();
        check("merge_sdone", sdone[0], 1);
        check("merge_data_unchanged", rdata[0], 32'hDEADBEEF);
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'b0000);
        tick();
        check("merge_ldone", ldone[0], 1);
        check("merge_data", rdata[0], 32'hDE22BE44);
        idle(0);
        tick();

        // Simultaneous load and store: store wins, load is dropped
        req(0, 1'b1, 1'b1, 32'h44, 32'h55AA55AA, 4'b1111);
        tick();
        check("both_sdone", sdone[0], 1);
        check("both_ldone", ldone[0], 0);
        idle(0);
        tick();
        check("both_no_late_ldone", ldone[0], 0);
        check("both_no_late_sdone", sdone[0], 0);
        check("both_data_unchanged", rdata[0], 32'hDE22BE44);
        req(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'b0000);
        tick();
        check("both_readback_ldone", ldone[0], 1);
        check("both_readback_data", rdata[0], 32'h55AA55AA);
        idle(0);
        tick();

        // Three wait states: store, then a load held while not ready
        req(1, 1'b0, 1'b1, 32'h100, 32'h12345678, 4'b1111);
        tick();
        check("ws3_n0_ready", ready[1], 0);
        check("ws3_n0_sdone", sdone[1], 0);
        req(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'b0000);
        tick();
        check("ws3_n1_ready", ready[1], 0);
        tick();
        check("ws3_n2_ready", ready[1], 0);
        check("ws3_n2_sdone", sdone[1], 0);
        tick();
        check("ws3_resp_sdone", sdone[1], 1);
        check("ws3_resp_ldone", ldone[1], 0);
        check("ws3_resp_ready", ready[1], 1);
        tick();
        check("ws3_held_acc_ready", ready[1], 0);
        check("ws3_held_acc_sdone", sdone[1], 0);
        idle(1);
        tick();
        check("ws3_ld_w2_ldone", ldone[1], 0);
        tick();
        check("ws3_ld_w3_ldone", ldone[1], 0);
        check("ws3_ld_w3_ready", ready[1], 0);
        tick();
        check("ws3_ld_ldone", ldone[1], 1);
        check("ws3_ld_data",  rdata[1], 32'h12345678);
        tick();
        check("ws3_ld_pulse_end", ldone[1], 0);
        check("ws3_ld_ready", ready[1], 1);

        // Two wait states: reset lands on a store's RESP-entry edge
        req(2, 1'b0, 1'b1, 32'h80, 32'h0BADC0DE, 4'b1111);
        tick();
        idle(2);
        check("ws2_pre_ready", ready[2], 0);
        tick();
        tick();
        check("ws2_pre_sdone", sdone[2], 1);
        tick();
        check("ws2_pre_idle", sdone[2], 0);
        req(2, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 4'b1111);
        tick();
        idle(2);
        tick();
        check("ws2_rst_wait2_ready", ready[2], 0);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        check("ws2_rst_sdone", sdone[2], 0);
        check("ws2_rst_ready", ready[2], 1);
        tick();
        check("ws2_rst_no_late_sdone", sdone[2], 0);
        req(2, 1'b1, 1'b0, 32'h80 + (32'd4 << 10), 32'h0, 4'b0000);
        tick();
        idle(2);
        tick();
        check("ws2_alias_wait_ldone", ldone[2], 0);
        tick();
        check("ws2_alias_ldone", ldone[2], 1);
        check("ws2_alias_data",  rdata[2], 32'h0BADC0DE);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
